msi_directory_ctrl: RTL

MSI_DIRECTORY_CTRL -- requirements
Module: msi_directory_ctrl

---
 rtl/msi_directory_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/msi_directory_ctrl.sv
// MSI coherence directory controller: captures one request, resolves the next
// cache/directory states and coherence message, and issues an optional writeback.
module msi_directory_ctrl (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic [1:0] WriteRead,
    input  logic [1:0] HitMiss,
    input  logic [2:0] stateCache,
    input  logic [2:0] stateCache2,
    input  logic [2:0] stateDiretorio,
    output logic [2:0] nextCache,
    output logic [2:0] nextCache2,
    output logic [2:0] nextDiretorio,
    output logic [2:0] msg,
    output logic       writeBack,
    output logic       respValid,
    output logic       errorFlag,
    output logic [7:0] txnCount,
    output logic [7:0] wbCount
);

    localparam logic [2:0] ST_I = 3'b001;
    localparam logic [2:0] ST_S = 3'b010;
    localparam logic [2:0] ST_M = 3'b011;

    localparam logic [2:0] MSG_NONE       = 3'b000;
    localparam logic [2:0] MSG_READ_MISS  = 3'b001;
    localparam logic [2:0] MSG_WRITE_MISS = 3'b010;
    localparam logic [2:0] MSG_INVALIDATE = 3'b011;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, RESPOND} fsm_t;

    fsm_t state, state_nxt;

    logic [1:0] wr_p0, hm_p0;
    logic [2:0] sc_p0, sc2_p0, sd_p0;

    logic       illegal;
    logic       is_write, is_hit, wb_need;
    logic [2:0] lk_cache, lk_cache2, lk_dir, lk_msg;

    function automatic logic st_ok(input logic [2:0] s);
        return (s == ST_I) || (s == ST_S) || (s == ST_M);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign reqReady = (state == IDLE) && !Reset;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (reqValid) state_nxt = LOOKUP;
            LOOKUP:    state_nxt = wb_need ? WRITEBACK : RESPOND;
            WRITEBACK: state_nxt = RESPOND;
            RESPOND:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // ---- p0: request capture (data path, no reset needed) ----
    always_ff @(posedge Clock) begin
        if (state == IDLE && reqValid) begin
            wr_p0  <= WriteRead;
            hm_p0  <= HitMiss;
            sc_p0  <= stateCache;
            sc2_p0 <= stateCache2;
            sd_p0  <= stateDiretorio;
        end
    end

    // ---- lookup: protocol table evaluated on the captured request ----
    always_comb begin
        is_write = wr_p0[0];
        is_hit   = hm_p0[0];
        illegal  = !st_ok(sc_p0) || !st_ok(sc2_p0) || !st_ok(sd_p0) ||
                   (wr_p0 > 2'b01) || (hm_p0 > 2'b01) ||
                   (is_hit && sc_p0 == ST_I) ||
                   (sc_p0 == ST_M && sc2_p0 == ST_M);
        lk_cache  = sc_p0;
        lk_cache2 = sc2_p0;
        lk_dir    = sd_p0;
        lk_msg    = MSG_NONE;
        wb_need   = 1'b0;
        if (!illegal) begin
            if (is_write && !is_hit) begin
                lk_cache = ST_M;
                lk_msg   = MSG_WRITE_MISS;
            end else if (is_write) begin
                lk_cache = ST_M;
                lk_msg   = (sc_p0 == ST_S) ? MSG_INVALIDATE : MSG_NONE;
            end else if (!is_hit) begin
                lk_cache = ST_S;
                lk_msg   = MSG_READ_MISS;
            end
            if (is_write)
                lk_cache2 = ST_I;
            else if (!is_hit && sc2_p0 == ST_M)
                lk_cache2 = ST_S;
            // Both writeback sources collapse into a single pulse.
            wb_need = (sc_p0 == ST_M && !is_hit) ||
                      (sc2_p0 == ST_M && (!is_hit || is_write));
            if (lk_cache == ST_M || lk_cache2 == ST_M)
                lk_dir = ST_M;
            else if (lk_cache == ST_S || lk_cache2 == ST_S)
                lk_dir = ST_S;
            else
                lk_dir = ST_I;
        end
    end

    // ---- response registers: loaded on entry to RESPOND, held otherwise ----
    always_ff @(posedge Clock) begin
        if (Reset) begin
            nextCache     <= ST_I;
            nextCache2    <= ST_I;
            nextDiretorio <= ST_I;
            msg           <= MSG_NONE;
            errorFlag     <= 1'b0;
            writeBack     <= 1'b0;
            respValid     <= 1'b0;
            txnCount      <= 8'd0;
            wbCount       <= 8'd0;
        end else begin
            writeBack <= (state_nxt == WRITEBACK);
            respValid <= (state_nxt == RESPOND);
            if (state_nxt == WRITEBACK)
                wbCount <= sat_inc(wbCount);
            if (state_nxt == RESPOND) begin
                nextCache     <= lk_cache;
                nextCache2    <= lk_cache2;
                nextDiretorio <= lk_dir;
                msg           <= lk_msg;
                errorFlag     <= illegal;
                txnCount      <= txnCount + 8'd1;
            end
        end
    end

endmodule
